// File: rtl/serial_operand_tx_if.sv
// serial_operand_tx_if -- bundles the request, serial-adder and result
// signals of serial_operand_tx. The master modport is the transmitter.
// The slave modport is the environment, which issues requests and models the adder.
interface serial_operand_tx_if;
    // Request side
    logic       start;
    logic [3:0] opa;
    logic [3:0] opb;
    logic       cin;

    // Serial adder side
    logic       a_out;
    logic       b_out;
    logic       cin_out;
    logic       adder_rst;
    logic [3:0] sum_in;
    logic       cout_in;
    logic       valid_in;

    // Status and result
    logic       busy;
    logic [4:0] result;
    logic       result_valid;
    logic       timeout_err;

    modport master (
        input  start, opa, opb, cin, sum_in, cout_in, valid_in,
        output a_out, b_out, cin_out, adder_rst, busy, result, result_valid,
               timeout_err
    );

    modport slave (
        output start, opa, opb, cin, sum_in, cout_in, valid_in,
        input  a_out, b_out, cin_out, adder_rst, busy, result, result_valid,
               timeout_err
    );
endinterface

// File: rtl/serial_operand_tx.sv
// serial_operand_tx -- takes a pair of 4-bit operands plus a carry-in.
// It clears an external serial adder for one cycle, shifts both operands
// out LSB first over four cycles, and then waits for the adder to return
// {cout, sum}.
// Every output comes straight from a flop.
// Optional feature: define SERTX_TIMEOUT_EN to give up after TIMEOUT_CYCLES
// WAIT cycles with no valid_in. A timeout sets the sticky timeout_err flag.
// When the macro is absent, the block waits forever and timeout_err is 0.
module serial_operand_tx #(
    parameter int TIMEOUT_CYCLES = 8
) (
    input  logic                        clk,
    input  logic                        rst,   // asynchronous, active-low
    serial_operand_tx_if.master         io
);

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_SHIFT = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    state_e            state_q,        state_d;
    logic [1:0]        bit_cnt_q,      bit_cnt_d;
    logic [TO_W-1:0]   to_cnt_q,       to_cnt_d;
    logic [3:0]        opa_q,          opa_d;
    logic [3:0]        opb_q,          opb_d;
    logic              a_out_q,        a_out_d;
    logic              b_out_q,        b_out_d;
    logic              cin_out_q,      cin_out_d;
    logic              adder_rst_q,    adder_rst_d;
    logic              busy_q,         busy_d;
    logic [4:0]        result_q,       result_d;
    logic              result_valid_q, result_valid_d;
    logic              timeout_err_q,  timeout_err_d;

    // Next-state and next-output decode. All outputs are computed here from the
    // upcoming state, so they can be registered without adding a cycle of lag.
    always_comb begin
        // NOTE: every signal gets a default before the case statement. A path that
        // leaves a signal unassigned would otherwise infer a latch.
        state_d        = state_q;
        bit_cnt_d      = bit_cnt_q;
        to_cnt_d       = to_cnt_q;
        opa_d          = opa_q;
        opb_d          = opb_q;
        a_out_d        = 1'b0;
        b_out_d        = 1'b0;
        cin_out_d      = cin_out_q;
        adder_rst_d    = 1'b0;
        result_d       = result_q;
        result_valid_d = 1'b0;
        timeout_err_d  = timeout_err_q;

        unique case (state_q)
            ST_IDLE: begin
                cin_out_d = 1'b0;
                if (io.start) begin
                    opa_d         = io.opa;
                    opb_d         = io.opb;
                    cin_out_d     = io.cin;
                    adder_rst_d   = 1'b1;
                    timeout_err_d = 1'b0;
                    bit_cnt_d     = '0;
                    to_cnt_d      = '0;
                    state_d       = ST_CLEAR;
                end
            end

            ST_CLEAR: begin
                // The first SHIFT cycle presents bit 0.
                bit_cnt_d = '0;
                a_out_d   = opa_q[0];
                b_out_d   = opb_q[0];
                state_d   = ST_SHIFT;
            end

            ST_SHIFT: begin
                if (bit_cnt_q == 2'd3) begin
                    bit_cnt_d = '0;
                    to_cnt_d  = '0;
                    state_d   = ST_WAIT;
                end else begin
                    bit_cnt_d = bit_cnt_q + 2'd1;
                    a_out_d   = opa_q[bit_cnt_d];
                    b_out_d   = opb_q[bit_cnt_d];
                end
            end

            ST_WAIT: begin
                if (io.valid_in) begin
                    result_d       = {io.cout_in, io.sum_in};
                    result_valid_d = 1'b1;
                    cin_out_d      = 1'b0;
                    state_d        = ST_IDLE;
                end else begin
`ifdef SERTX_TIMEOUT_EN
                    if (to_cnt_q == TO_LAST) begin
                        timeout_err_d = 1'b1;
                        cin_out_d     = 1'b0;
                        state_d       = ST_IDLE;
                    end else begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`else
                    // The WAIT-cycle count only saturates here. Nothing acts on it.
                    if (to_cnt_q != TO_LAST) begin
                        to_cnt_d = to_cnt_q + 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers, cleared immediately when rst falls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            bit_cnt_q      <= '0;
            to_cnt_q       <= '0;
            opa_q          <= '0;
            opb_q          <= '0;
            a_out_q        <= 1'b0;
            b_out_q        <= 1'b0;
            cin_out_q      <= 1'b0;
            adder_rst_q    <= 1'b0;
            busy_q         <= 1'b0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the values that
            // were present before the edge, whatever order the statements appear in.
            state_q        <= state_d;
            bit_cnt_q      <= bit_cnt_d;
            to_cnt_q       <= to_cnt_d;
            opa_q          <= opa_d;
            opb_q          <= opb_d;
            a_out_q        <= a_out_d;
            b_out_q        <= b_out_d;
            cin_out_q      <= cin_out_d;
            adder_rst_q    <= adder_rst_d;
            busy_q         <= busy_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign io.a_out        = a_out_q;
    assign io.b_out        = b_out_q;
    assign io.cin_out      = cin_out_q;
    assign io.adder_rst    = adder_rst_q;
    assign io.busy         = busy_q;
    assign io.result       = result_q;
    assign io.result_valid = result_valid_q;
`ifdef SERTX_TIMEOUT_EN
    assign io.timeout_err  = timeout_err_q;
`else
    assign io.timeout_err  = 1'b0;
`endif

endmodule

// File: tb/tb_serial_operand_tx.sv
// tb_serial_operand_tx -- directed bench for serial_operand_tx. The bench
// plays the part of the serial adder and returns hand-computed sums.
// All activity happens on the falling edge.
module tb_serial_operand_tx;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   rv_count;
    int   rv_before;

    serial_operand_tx_if bus ();

    serial_operand_tx #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count result_valid pulses so single-pulse behaviour can be checked.
    always @(negedge clk) begin
        if (bus.result_valid === 1'b1) rv_count++;
    end

    // Guard against a run that never ends.
    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a falling edge. Presents a request, lets one rising edge
    // accept it, and checks the CLEAR cycle.
    task automatic start_xfer(input logic [3:0] a, input logic [3:0] b, input logic c);
        bus.opa   = a;
        bus.opb   = b;
        bus.cin   = c;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("clear_adder_rst", bus.adder_rst, 1'b1);
        check("clear_busy",      bus.busy,      1'b1);
        check("clear_cin_out",   bus.cin_out,   c);
        check("clear_a_out",     bus.a_out,     1'b0);
    endtask

    // Checks the four SHIFT cycles and the first WAIT cycle. ea[n] and eb[n]
    // are the bits expected in SHIFT cycle n. When repulse is set, a new
    // start with different operands is pulsed during bit 1, and it must be
    // ignored. When noise is set, valid_in is held high during SHIFT, and
    // it must be ignored as well.
    task automatic shift_phase(input logic [3:0] ea, input logic [3:0] eb, input logic ec,
                               input logic repulse, input logic noise);
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check($sformatf("shift%0d_a_out", n),     bus.a_out,        ea[n]);
            check($sformatf("shift%0d_b_out", n),     bus.b_out,        eb[n]);
            check($sformatf("shift%0d_cin_out", n),   bus.cin_out,      ec);
            check($sformatf("shift%0d_adder_rst", n), bus.adder_rst,    1'b0);
            check($sformatf("shift%0d_rv", n),        bus.result_valid, 1'b0);
            if (repulse && n == 1) begin
                bus.start = 1'b1;
                bus.opa   = 4'hF;
                bus.opb   = 4'hF;
                bus.cin   = ~ec;
            end else begin
                bus.start = 1'b0;
            end
            if (noise && n == 3) begin
                bus.valid_in = 1'b0;
                bus.sum_in   = 4'h0;
                bus.cout_in  = 1'b0;
            end
        end
        @(negedge clk);
        check("wait_busy",    bus.busy,         1'b1);
        check("wait_a_out",   bus.a_out,        1'b0);
        check("wait_b_out",   bus.b_out,        1'b0);
        check("wait_cin_out", bus.cin_out,      ec);
        check("wait_rv",      bus.result_valid, 1'b0);
    endtask

    // Called at a falling edge in WAIT. The bench returns the adder result,
    // and the next falling edge is the result_valid cycle.
    task automatic finish_wait(input logic [3:0] s, input logic co, input logic [4:0] exp_res);
        bus.sum_in   = s;
        bus.cout_in  = co;
        bus.valid_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        check("done_rv",     bus.result_valid, 1'b1);
        check("done_result", bus.result,       exp_res);
        check("done_busy",   bus.busy,         1'b0);
    endtask

    // The cycle after completion: the pulse has ended and result is held.
    task automatic check_hold(input logic [4:0] exp_res);
        @(negedge clk);
        check("hold_rv",     bus.result_valid, 1'b0);
        check("hold_result", bus.result,       exp_res);
        check("hold_busy",   bus.busy,         1'b0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rv_count     = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.opa      = 4'h0;
        bus.opb      = 4'h0;
        bus.cin      = 1'b0;
        bus.sum_in   = 4'h0;
        bus.cout_in  = 1'b0;
        bus.valid_in = 1'b0;

        // Reset state
        #2 rst = 1'b0;
        #10;
        check("rst_a_out",     bus.a_out,        1'b0);
        check("rst_b_out",     bus.b_out,        1'b0);
        check("rst_cin_out",   bus.cin_out,      1'b0);
        check("rst_adder_rst", bus.adder_rst,    1'b0);
        check("rst_busy",      bus.busy,         1'b0);
        check("rst_result",    bus.result,       5'h00);
        check("rst_rv",        bus.result_valid, 1'b0);
        check("rst_timeout",   bus.timeout_err,  1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // opa=5, opb=3, cin=0: a 1,0,1,0  b 1,1,0,0  sum 8
        start_xfer(4'd5, 4'd3, 1'b0);
        shift_phase(4'b0101, 4'b0011, 1'b0, 1'b0, 1'b0);
        finish_wait(4'd8, 1'b0, 5'b01000);
        check_hold(5'b01000);

        // opa=15, opb=1, cin=1: sum 1 with cout 1. valid_in is noise during SHIFT.
        start_xfer(4'd15, 4'd1, 1'b1);
        bus.valid_in = 1'b1;
        bus.sum_in   = 4'hA;
        bus.cout_in  = 1'b1;
        shift_phase(4'b1111, 4'b0001, 1'b1, 1'b0, 1'b1);
        check("noise_result_kept", bus.result, 5'b01000);
        finish_wait(4'd1, 1'b1, 5'h11);
        check_hold(5'h11);

        // opa=6, opb=9, cin=0 with start re-pulsed in SHIFT: 6+9 = 15
        rv_before = rv_count;
        start_xfer(4'd6, 4'd9, 1'b0);
        shift_phase(4'b0110, 4'b1001, 1'b0, 1'b1, 1'b0);
        finish_wait(4'hF, 1'b0, 5'h0F);
        check_hold(5'h0F);
        check("repulse_single_rv", rv_count - rv_before, 1);

        // Reset during SHIFT bit 2 of opa=5, opb=3, cin=1
        start_xfer(4'd5, 4'd3, 1'b1);
        @(negedge clk);
        check("rs_bit0_a", bus.a_out, 1'b1);
        @(negedge clk);
        check("rs_bit1_b", bus.b_out, 1'b1);
        @(negedge clk);
        check("rs_bit2_a", bus.a_out, 1'b1);
        check("rs_busy_before", bus.busy, 1'b1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_a_out",   bus.a_out,        1'b0);
        check("mid_rst_b_out",   bus.b_out,        1'b0);
        check("mid_rst_cin_out", bus.cin_out,      1'b0);
        check("mid_rst_busy",    bus.busy,         1'b0);
        check("mid_rst_result",  bus.result,       5'h00);
        check("mid_rst_rv",      bus.result_valid, 1'b0);
        check("mid_rst_timeout", bus.timeout_err,  1'b0);
        @(negedge clk);
        check("rst_held_busy", bus.busy, 1'b0);
        rst = 1'b1;

        // First transfer after release: opa=2, opb=7, cin=0, sum 9
        start_xfer(4'd2, 4'd7, 1'b0);
        shift_phase(4'b0010, 4'b0111, 1'b0, 1'b0, 1'b0);
        finish_wait(4'd9, 1'b0, 5'h09);

        // Start issued in the result_valid cycle: opa=10, opb=7, so 17 gives sum 1, cout 1
        start_xfer(4'd10, 4'd7, 1'b0);
        shift_phase(4'b1010, 4'b0111, 1'b0, 1'b0, 1'b0);
        finish_wait(4'd1, 1'b1, 5'h11);
        check_hold(5'h11);

        // valid_in never arrives
        start_xfer(4'd1, 4'd1, 1'b0);
        shift_phase(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0);
`ifdef SERTX_TIMEOUT_EN
        // The first WAIT cycle has been seen, and seven more remain before the timeout.
        for (int i = 2; i <= 8; i++) begin
            @(negedge clk);
            check($sformatf("to_wait%0d_busy", i), bus.busy, 1'b1);
        end
        @(negedge clk);
        check("to_busy",    bus.busy,         1'b0);
        check("to_err",     bus.timeout_err,  1'b1);
        check("to_rv",      bus.result_valid, 1'b0);
        check("to_result",  bus.result,       5'h11);
        @(negedge clk);
        check("to_sticky",  bus.timeout_err,  1'b1);
        // The next accepted start clears the flag: 3+4+1 = 8
        start_xfer(4'd3, 4'd4, 1'b1);
        check("to_cleared", bus.timeout_err,  1'b0);
        shift_phase(4'b0011, 4'b0100, 1'b1, 1'b0, 1'b0);
        finish_wait(4'd8, 1'b0, 5'h08);
        check_hold(5'h08);
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
        end
        check("nto_busy", bus.busy,        1'b1);
        check("nto_err",  bus.timeout_err, 1'b0);
        check("nto_rv",   bus.result_valid, 1'b0);
        finish_wait(4'd2, 1'b0, 5'h02);
        check_hold(5'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
